// File: rtl/bellek_hakemi_pkg.sv
// rtl/bellek_hakemi_pkg.sv - shared state, service codes and block defaults for the memory arbiter
package bellek_hakemi_pkg;

  typedef enum logic [1:0] {
    BOSTA  = 2'd0,
    BB_OKU = 2'd1,
    VB_OKU = 2'd2,
    VB_YAZ = 2'd3
  } durum_t;

  typedef enum logic {
    HIZMET_BB = 1'b0,
    HIZMET_VB = 1'b1
  } hizmet_t;

  localparam int BLOK_KELIME_VARSAYILAN = 4;

  // Block-aligned base: clears the byte offset inside one burst-sized block.
  function automatic logic [31:0] taban_adres(input logic [31:0] adres, input int blok_kelime);
    return adres & ~(32'(4 * blok_kelime) - 32'd1);
  endfunction

endpackage

// File: rtl/bellek_burst_sayaci.sv
// rtl/bellek_burst_sayaci.sv - word counter for one memory burst with clear and last-word flag
module bellek_burst_sayaci #(
  parameter int BLOK_KELIME = 4,
  parameter int SAYAC_BIT   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 temizle,
  input  logic                 artir,
  output logic [SAYAC_BIT-1:0] sayac,
  output logic                 son
);

  assign son = (sayac == SAYAC_BIT'(BLOK_KELIME - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sayac <= '0;
    end else if (temizle || (artir && son)) begin
      sayac <= '0;
    end else if (artir) begin
      sayac <= sayac + SAYAC_BIT'(1);
    end
  end

endmodule

// File: rtl/bellek_hakemi.sv
// rtl/bellek_hakemi.sv - shares one main-memory port between instruction and data cache bursts
module bellek_hakemi
  import bellek_hakemi_pkg::*;
#(
  parameter int BLOK_KELIME = BLOK_KELIME_VARSAYILAN,
  parameter int SAYAC_BIT   = $clog2(BLOK_KELIME)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 bb_istek_i,
  input  logic [31:0]          bb_adres_i,
  input  logic                 bb_iptal_i,
  output logic                 bb_kabul_o,
  output logic [31:0]          bb_veri_o,
  output logic                 bb_veri_gecerli_o,
  output logic                 bb_bitti_o,
  input  logic                 vb_istek_i,
  input  logic                 vb_yaz_i,
  input  logic [31:0]          vb_adres_i,
  input  logic [31:0]          vb_yaz_veri_i,
  output logic                 vb_yaz_veri_al_o,
  output logic                 vb_kabul_o,
  output logic [31:0]          vb_veri_o,
  output logic                 vb_veri_gecerli_o,
  output logic                 vb_bitti_o,
  output logic [SAYAC_BIT-1:0] kelime_o,
  output logic                 bellek_istek_o,
  output logic                 bellek_yaz_o,
  output logic [31:0]          bellek_adres_o,
  output logic [31:0]          bellek_yaz_veri_o,
  input  logic                 bellek_hazir_i,
  input  logic [31:0]          bellek_veri_i
);

  durum_t                 durum, durum_sonraki;
  hizmet_t                son_hizmet, son_hizmet_sonraki;
  logic [31:0]            taban, taban_sonraki;
  logic                   iptal, iptal_sonraki;
  logic                   bb_sec, vb_sec;
  logic [SAYAC_BIT-1:0]   sayac;
  logic                   son;
  logic                   kelime_bitti;
  logic                   bb_uygun;
  logic                   bb_bastir;

  assign kelime_bitti = (durum != BOSTA) && bellek_hazir_i;
  assign bb_uygun     = bb_istek_i && !bb_iptal_i;
  // A redirect suppresses delivery from its own cycle onward, not just after it registers.
  assign bb_bastir    = iptal || bb_iptal_i;

  bellek_burst_sayaci #(
    .BLOK_KELIME (BLOK_KELIME),
    .SAYAC_BIT   (SAYAC_BIT)
  ) u_sayac (
    .clk     (clk_i),
    .rst     (rst_i),
    .temizle (durum == BOSTA),
    .artir   (kelime_bitti),
    .sayac   (sayac),
    .son     (son)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum      <= BOSTA;
      son_hizmet <= HIZMET_VB;
      taban      <= '0;
      iptal      <= 1'b0;
    end else begin
      durum      <= durum_sonraki;
      son_hizmet <= son_hizmet_sonraki;
      taban      <= taban_sonraki;
      iptal      <= iptal_sonraki;
    end
  end

  always_comb begin
    durum_sonraki      = durum;
    son_hizmet_sonraki = son_hizmet;
    taban_sonraki      = taban;
    iptal_sonraki      = iptal;
    bb_sec             = 1'b0;
    vb_sec             = 1'b0;
    case (durum)
      BOSTA: begin
        iptal_sonraki = 1'b0;
        if (bb_uygun && (!vb_istek_i || son_hizmet == HIZMET_VB)) begin
          bb_sec = 1'b1;
        end else if (vb_istek_i) begin
          vb_sec = 1'b1;
        end
        if (bb_sec) begin
          durum_sonraki      = BB_OKU;
          son_hizmet_sonraki = HIZMET_BB;
          taban_sonraki      = taban_adres(bb_adres_i, BLOK_KELIME);
        end else if (vb_sec) begin
          durum_sonraki      = vb_yaz_i ? VB_YAZ : VB_OKU;
          son_hizmet_sonraki = HIZMET_VB;
          taban_sonraki      = taban_adres(vb_adres_i, BLOK_KELIME);
        end
      end
      BB_OKU: begin
        if (bb_iptal_i) iptal_sonraki = 1'b1;
        if (kelime_bitti && son) begin
          durum_sonraki = BOSTA;
          iptal_sonraki = 1'b0;
        end
      end
      default: begin
        if (kelime_bitti && son) durum_sonraki = BOSTA;
      end
    endcase
  end

  // Grants are combinational from the request, so hold them off while reset is asserted.
  assign bb_kabul_o        = bb_sec && !rst_i;
  assign vb_kabul_o        = vb_sec && !rst_i;

  assign bellek_istek_o    = (durum != BOSTA);
  assign bellek_yaz_o      = (durum == VB_YAZ);
  assign bellek_adres_o    = (durum != BOSTA) ? (taban + (32'(sayac) << 2)) : '0;
  assign bellek_yaz_veri_o = (durum == VB_YAZ) ? vb_yaz_veri_i : '0;
  assign kelime_o          = sayac;

  assign bb_veri_o         = (durum == BB_OKU) ? bellek_veri_i : '0;
  assign bb_veri_gecerli_o = (durum == BB_OKU) && bellek_hazir_i && !bb_bastir;
  assign bb_bitti_o        = bb_veri_gecerli_o && son;

  assign vb_veri_o         = (durum == VB_OKU) ? bellek_veri_i : '0;
  assign vb_veri_gecerli_o = (durum == VB_OKU) && bellek_hazir_i;
  assign vb_yaz_veri_al_o  = (durum == VB_YAZ) && bellek_hazir_i;
  assign vb_bitti_o        = ((durum == VB_OKU) || (durum == VB_YAZ)) && bellek_hazir_i && son;

endmodule
